// File: rtl/hog_pixel_unpacker.sv
// Unpacks WORD_WIDTH packed pixel words into a byte-serial, frame-bounded pixel stream (lane 0 first).
// Optional stall counter enabled by defining HOG_UNPACK_STALL_CNT_EN.
module hog_pixel_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 128
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [WORD_WIDTH-1:0]                       in_word,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [DATA_WIDTH-1:0]                       out_pixel,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_eol,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]   pixel_count,
  output logic [31:0]                                 stall_count
);

  localparam int LANES  = WORD_WIDTH / DATA_WIDTH;
  localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  out_valid_s;
  logic                  in_ready_s;
  logic                  last_pix_s;
  logic                  last_lane_s;

  assign out_valid_s = (state_q == STREAM);
  assign last_pix_s  = (cnt_q == PIX_LAST);
  assign last_lane_s = (lane_q == LANE_LAST);
  // Refill on the edge the last lane leaves, but never past the final pixel of the frame.
  assign in_ready_s  = (state_q == LOAD) ||
                       (out_valid_s && last_lane_s && out_ready && !last_pix_s);

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_pixel   = out_valid_s ? buf_q[DATA_WIDTH*int'(lane_q) +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
  assign out_eol     = out_valid_s && (col_q == COL_LAST);
  assign busy        = (state_q == LOAD) || (state_q == STREAM);
  assign frame_done  = (state_q == DONE);
  assign pixel_count = cnt_q;

  // State, buffer and position registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      lane_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    lane_d  = lane_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          buf_d   = in_word;
          lane_d  = '0;
          state_d = STREAM;
        end else begin
          state_d = LOAD;
        end
      end
      STREAM: begin
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (last_pix_s) begin
            state_d = DONE;
          end else if (last_lane_s) begin
            if (in_valid) begin
              buf_d  = in_word;
              lane_d = '0;
            end else begin
              state_d = LOAD;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef HOG_UNPACK_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles the downstream back-pressures a valid pixel
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = 32'd0;
    end else if (out_valid_s && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: doc/hog_pixel_unpacker.md
Name: hog_pixel_unpacker

Overview:
- Upstream feeder for the HOG pipeline's pixel input port (8-bit pixel, valid/ready).
- Accepts 32-bit packed pixel words written by the HPS side through a word FIFO/PIO and unpacks them into a byte-serial pixel stream, least-significant byte first.
- Frames the stream to exactly IMG_WIDTH*IMG_HEIGHT pixels per start command.
- Reports progress, row position and frame completion.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- WORD_WIDTH, 32, packed input word width in bits; must be a multiple of DATA_WIDTH. LANES = WORD_WIDTH/DATA_WIDTH.
- IMG_WIDTH, 64, pixels per row; must be a multiple of LANES.
- IMG_HEIGHT, 128, rows per frame.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
- start  in  1  one-cycle pulse; begins a frame; ignored unless the FSM is in IDLE.
- in_word  in  WORD_WIDTH  packed pixels; lane 0 = bits [DATA_WIDTH-1:0].
- in_valid  in  1  in_word valid.
- in_ready  out  1  block accepts in_word this cycle.
- out_pixel  out  DATA_WIDTH  unpacked pixel to the HOG pixel input.
- out_valid  out  1  out_pixel valid.
- out_ready  in  1  downstream accepts out_pixel.
- out_eol  out  1  qualifies out_pixel as the last pixel of a row.
- busy  out  1  high in LOAD/STREAM.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.
- pixel_count  out  clog2(IMG_WIDTH*IMG_HEIGHT+1)  pixels accepted downstream in the current frame.
- stall_count  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0), all outputs 0: in_ready, out_valid, out_pixel, out_eol, busy, frame_done, pixel_count, stall_count. FSM goes to IDLE. Word buffer is emptied and the lane index set to 0.
  - Reset mid-frame aborts the frame: no frame_done; the partial word is discarded.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE
  - in_ready=0, out_valid=0.
  - start=1 -> LOAD. pixel_count, column and row counters are cleared on the same edge.
- LOAD
  - in_ready=1.
  - Handshake in_valid&&in_ready captures in_word into the word buffer and sets lane=0 -> STREAM.
- STREAM
  - out_valid=1; out_pixel = buffer lane [lane].
  - On out_valid&&out_ready: lane increments, pixel_count increments, column increments.
  - out_eol=1 when column==IMG_WIDTH-1. On that handshake, column wraps to 0 and row increments.
- Refill without bubbles:
  - in_ready=1 in STREAM while lane==LANES-1 and out_ready=1 and the frame is not on its final pixel.
  - A word accepted on that edge loads the buffer with lane=0 and the state stays STREAM. Back-to-back words therefore give 1 pixel/cycle.
  - If the last lane is consumed but no word is accepted -> LOAD (out_valid drops next cycle).
- Frame end: the handshake on pixel IMG_WIDTH*IMG_HEIGHT-1 goes to DONE. in_ready stays 0 on that cycle, so no word beyond the frame is consumed.
- DONE: frame_done=1 for exactly one cycle, busy=0; next state IDLE. pixel_count holds the final value (8192 by default) until the next start.
- start while not in IDLE is ignored, with no effect on counters.
- out_pixel and out_eol are held stable while out_valid=1 and out_ready=0.
- in_valid with in_ready=0 is ignored; the upstream holds the word.
- Latency: start -> in_ready = 1 cycle. Word accept -> first out_valid = 1 cycle.

Optional Feature:
- Macro HOG_UNPACK_STALL_CNT_EN.
- Defined:
  - stall_count increments by 1 on every cycle with out_valid=1 and out_ready=0, saturating at 32'hFFFF_FFFF.
  - Cleared on reset and on an accepted start.
  - Held through DONE/IDLE.
- Undefined: stall_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then start; feed words 0x03020100, 0x07060504 with out_ready=1 throughout -> out_pixel 0x00..0x07 on consecutive cycles after the first accept; pixel_count=8.
- Full default frame, 2048 words, in_valid and out_ready held 1 -> 8192 pixels with no bubble after the first. out_eol on pixels 63, 127, ..., 8191. frame_done pulses once, one cycle after pixel 8191. in_ready=0 afterwards; the 2049th word is not consumed.
- out_ready toggled 1,0,0,1 during a word -> out_pixel stable across the stalled cycles; no pixel lost or duplicated. With HOG_UNPACK_STALL_CNT_EN, stall_count=2.
- in_valid gap of 3 cycles after lane 3 -> state LOAD, out_valid=0 for those cycles; the stream resumes with the next word's lane 0.
- rst=0 for one cycle at pixel 100 -> all outputs 0 next cycle and no frame_done. A new start plus a full frame completes normally with pixel_count=8192.
- start pulsed at pixel 500 mid-frame -> ignored; the frame still ends at 8192 pixels with one frame_done.
